// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: computes real outcome/target, flags mispredicts,
// masks the wrong-path shadow and trains the 2-bit BHT read by the IF predictor.
module branch_resolve_unit #(
    parameter int IDX_W       = 4,
    parameter int FLUSH_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        stall,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs1_data,
    input  logic [31:0] ex_rs2_data,
    input  logic [31:0] ex_imm,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic [31:0] if_pc,
    output logic        if_bht_taken,
    output logic        res_valid,
    output logic        pc_Sel,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, REDIRECT, SHADOW} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   shadow_cnt, shadow_nxt;
    logic [1:0]         bht [2**IDX_W];

    logic               is_br, is_jal, is_jalr, is_cf;
    logic               cond, cond_ok, taken, mispred, resolve, train;
    logic [31:0]        target;
    logic [IDX_W-1:0]   bht_idx;
    logic               unused_if_pc;

    assign is_br   = (ex_opcode == OP_BRANCH);
    assign is_jal  = (ex_opcode == OP_JAL);
    assign is_jalr = (ex_opcode == OP_JALR);
    assign is_cf   = is_br | is_jal | is_jalr;

    always_comb begin
        cond    = 1'b0;
        cond_ok = 1'b1;
        case (ex_funct3)
            3'b000:  cond = (ex_rs1_data == ex_rs2_data);
            3'b001:  cond = (ex_rs1_data != ex_rs2_data);
            3'b100:  cond = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
            3'b101:  cond = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
            3'b110:  cond = (ex_rs1_data <  ex_rs2_data);
            3'b111:  cond = (ex_rs1_data >= ex_rs2_data);
            default: cond_ok = 1'b0;
        endcase
    end

    assign taken   = is_br ? cond : 1'b1;
    assign target  = is_jalr ? ((ex_rs1_data + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
    assign mispred = (taken != ex_pred_taken) |
                     (taken & ex_pred_taken & (target != ex_pred_target));
    assign resolve = ex_valid & ~stall & (state == IDLE) & is_cf;
    assign train   = resolve & is_br & cond_ok;
    assign bht_idx = ex_pc[IDX_W+1:2];

    // Pre-write read: a same-cycle training write is not forwarded.
    assign if_bht_taken = bht[if_pc[IDX_W+1:2]][1];
    assign unused_if_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Shadow progresses even under stall so the flush window is time-based.
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow_cnt;
        case (state)
            IDLE: begin
                if (resolve && mispred) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                if (FLUSH_DEPTH > 1) begin
                    state_nxt  = SHADOW;
                    shadow_nxt = CNT_W'(FLUSH_DEPTH - 1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHADOW: begin
                shadow_nxt = (shadow_cnt != '0) ? shadow_cnt - 1'b1 : '0;
                if (shadow_cnt <= CNT_W'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shadow_cnt  <= '0;
            res_valid   <= 1'b0;
            pc_Sel      <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
            br_count    <= 32'd0;
            mis_count   <= 32'd0;
            for (int i = 0; i < 2**IDX_W; i++) bht[i] <= 2'b01;
        end else begin
            state       <= state_nxt;
            shadow_cnt  <= shadow_nxt;
            res_valid   <= resolve;
            pc_Sel      <= resolve & taken;
            redirect    <= resolve & mispred;
            redirect_pc <= (resolve && mispred) ? (taken ? target : ex_pc + 32'd4) : 32'd0;
            if (resolve)            br_count  <= br_count + 32'd1;
            if (resolve && mispred) mis_count <= mis_count + 32'd1;
            if (train) begin
                if (taken && bht[bht_idx] != 2'b11)       bht[bht_idx] <= bht[bht_idx] + 2'b01;
                else if (!taken && bht[bht_idx] != 2'b00) bht[bht_idx] <= bht[bht_idx] - 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expected
// resolve results; a negedge monitor pops and compares on every res_valid.
module tb_branch_resolve_unit;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, stall = 1'b0;
    logic [6:0]  ex_opcode = '0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_pc = '0, ex_rs1_data = '0, ex_rs2_data = '0, ex_imm = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0, if_pc = '0;
    logic        if_bht_taken, res_valid, pc_Sel, redirect;
    logic [31:0] redirect_pc, br_count, mis_count;

    typedef struct {
        logic        taken;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] br;
        logic [31:0] mis;
    } exp_t;

    exp_t        q[$];
    int          tests = 0, fails = 0;
    logic [31:0] exp_br = 0, exp_mis = 0;

    branch_resolve_unit #(.IDX_W(4), .FLUSH_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .if_pc(if_pc), .if_bht_taken(if_bht_taken), .res_valid(res_valid),
        .pc_Sel(pc_Sel), .redirect(redirect), .redirect_pc(redirect_pc),
        .br_count(br_count), .mis_count(mis_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One EX cycle of stimulus; a resolve expectation is queued when er=1.
    task automatic drive(input logic v, input logic st, input logic [6:0] op,
                         input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic pt,
                         input logic [31:0] ptgt, input logic er, input logic et,
                         input logic ed, input logic [31:0] erpc);
        exp_t e;
        @(posedge clk); #1;
        ex_valid = v; stall = st; ex_opcode = op; ex_funct3 = f3; ex_pc = pc;
        ex_rs1_data = rs1; ex_rs2_data = rs2; ex_imm = imm;
        ex_pred_taken = pt; ex_pred_target = ptgt;
        if (er) begin
            exp_br++;
            if (ed) exp_mis++;
            e.taken = et; e.redir = ed; e.rpc = erpc; e.br = exp_br; e.mis = exp_mis;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, ALU, 3'b000, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic chk_bht(input string name, input logic [31:0] pc, input logic exp);
        if_pc = pc; #1;
        chk(name, {31'd0, if_bht_taken}, {31'd0, exp});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_res_valid"},   {31'd0, res_valid}, 0);
        chk({tag, "_pc_Sel"},      {31'd0, pc_Sel},    0);
        chk({tag, "_redirect"},    {31'd0, redirect},  0);
        chk({tag, "_redirect_pc"}, redirect_pc,        0);
        chk({tag, "_br_count"},    br_count,           0);
        chk({tag, "_mis_count"},   mis_count,          0);
    endtask

    always @(negedge clk) begin
        if (!rst && redirect && !res_valid)
            chk("redirect_without_res_valid", {31'd0, redirect}, 0);
        if (!rst && res_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_res_valid", {31'd0, res_valid}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pc_Sel",    {31'd0, pc_Sel},   {31'd0, e.taken});
                chk("redirect",  {31'd0, redirect}, {31'd0, e.redir});
                if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
                chk("br_count",  br_count,  e.br);
                chk("mis_count", mis_count, e.mis);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        chk_bht("reset_bht0", 32'h0, 1'b0);

        // BEQ taken, predicted not-taken: redirect, then three masked cycles
        drive(1, 0, BR, 3'b000, 32'h100, 5, 5, 32'h20, 0, 0, 1, 1, 1, 32'h120);
        repeat (3) drive(1, 0, BR, 3'b001, 32'h44, 1, 2, 32'h8, 0, 0, 0, 0, 0, 0);
        drive(1, 0, BR, 3'b000, 32'h208, 1, 2, 32'h8, 0, 0, 1, 0, 0, 0);
        chk_bht("beq_trained_idx0", 32'h100, 1'b1);
        chk_bht("shadow_no_train_idx1", 32'h44, 1'b0);

        // BLT signed taken (correct), BLTU same operands not taken (mispredict)
        drive(1, 0, BR, 3'b100, 32'h300, 32'hFFFF_FFFF, 1, 32'h10, 1, 32'h310, 1, 1, 0, 0);
        drive(1, 0, BR, 3'b110, 32'h304, 32'hFFFF_FFFF, 1, 32'h10, 1, 32'h314, 1, 0, 1, 32'h308);
        idle(3);

        // JALR clears bit 0 of the target; never trains the BHT
        drive(1, 0, JALR, 3'b000, 32'h43C, 32'h2003, 0, 0, 1, 32'h2003, 1, 1, 1, 32'h2002);
        idle(3);
        chk_bht("jalr_no_train", 32'h43C, 1'b0);
        drive(1, 0, JAL, 3'b000, 32'h500, 0, 0, 32'h100, 1, 32'h600, 1, 1, 0, 0);

        // Saturate idx0 up, then down; check pre-write read during a write
        repeat (4) drive(1, 0, BR, 3'b001, 32'h40, 1, 2, 32'h8, 1, 32'h48, 1, 1, 0, 0);
        idle(1);
        chk_bht("bht_sat_taken", 32'h40, 1'b1);
        drive(1, 0, BR, 3'b001, 32'h40, 3, 3, 32'h8, 0, 0, 1, 0, 0, 0);
        drive(1, 0, BR, 3'b001, 32'h40, 3, 3, 32'h8, 0, 0, 1, 0, 0, 0);
        chk_bht("bht_read_old_on_write", 32'h40, 1'b1);
        repeat (2) drive(1, 0, BR, 3'b001, 32'h40, 3, 3, 32'h8, 0, 0, 1, 0, 0, 0);
        idle(1);
        chk_bht("bht_sat_not_taken", 32'h40, 1'b0);

        // Mispredict then stall through the shadow: window still expires on time
        drive(1, 0, BR, 3'b101, 32'h80, 5, 5, 32'h40, 0, 0, 1, 1, 1, 32'hC0);
        repeat (3) drive(1, 1, BR, 3'b000, 32'h88, 1, 1, 32'h8, 0, 0, 0, 0, 0, 0);
        drive(1, 0, BR, 3'b111, 32'h84, 1, 2, 32'h8, 0, 0, 1, 0, 0, 0);

        // Stall in IDLE, non-control-flow op, and unsupported funct3
        drive(1, 1, BR, 3'b000, 32'h90, 1, 1, 32'h8, 0, 0, 0, 0, 0, 0);
        drive(1, 0, ALU, 3'b000, 32'h94, 1, 1, 32'h8, 1, 32'h9C, 0, 0, 0, 0);
        drive(1, 0, BR, 3'b011, 32'h4C, 1, 1, 32'h4, 1, 32'h50, 1, 0, 1, 32'h50);
        idle(3);

        // Train idx5, mispredict, then reset in the middle of the shadow
        drive(1, 0, BR, 3'b000, 32'h14, 7, 7, 32'h10, 1, 32'h24, 1, 1, 0, 0);
        drive(1, 0, BR, 3'b001, 32'h18, 7, 7, 32'h10, 1, 32'h99, 1, 0, 1, 32'h1C);
        chk_bht("pre_reset_idx5", 32'h14, 1'b1);
        idle(1);
        @(posedge clk); #1;
        rst = 1'b1;
        ex_valid = 1'b1; ex_opcode = JAL; ex_pred_taken = 1'b0;
        chk("queue_empty_before_reset", q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0; ex_valid = 1'b0;
        exp_br = 0; exp_mis = 0;
        @(negedge clk);
        chk_zero("mid_shadow_reset");
        for (int i = 0; i < 16; i++) chk_bht("reset_bht_all", i * 4, 1'b0);

        drive(1, 0, JAL, 3'b000, 32'h700, 0, 0, 32'h4, 0, 0, 1, 1, 1, 32'h704);
        idle(5);
        chk("queue_empty_at_end", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
